// File: rtl/rf_pkg.sv
// Shared register-file write-back types and constants.
package rf_pkg;
  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NREGS    = 16;
  localparam int RF_ZERO_REG = 0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req;
endpackage

// File: rtl/rf_wq_fifo.sv
// Small in-order write-back queue; exposes every slot's valid/addr for the pending scoreboard.
module rf_wq_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push_i,
  input  logic                              pop_i,
  input  wb_req                             din_i,
  output wb_req                             dout_o,
  output logic                              empty_o,
  output logic                              full_o,
  output logic [DEPTH-1:0]                  ent_vld_o,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]   ent_addr_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req            mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_q, rd_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = ~|vld_q;
  assign full_o  = &vld_q;
  // Guarded so push and pop can never target the same slot in one cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];
  assign ent_vld_o = vld_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_addr_o[i] = mem_q[i].addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= ptr_inc(rd_q);
      end
      if (do_push) begin
        vld_q[wr_q] <= 1'b1;
        mem_q[wr_q] <= din_i;
        wr_q        <= ptr_inc(wr_q);
      end
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbitration of ALU and load write-backs onto the single register-file write port.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                nClear,
  input  logic                req0_valid,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                req1_ready,
  output logic                load,
  output logic [ADDR_W-1:0]   Caddr,
  output logic [DATA_W-1:0]   C,
  output logic [RF_NREGS-1:0] pending,
  output logic                busy
);
  localparam int NREQ = 2;

  logic  [NREQ-1:0]                         vld_in, push, pop, empty, full;
  wb_req [NREQ-1:0]                         din, head;
  logic  [NREQ-1:0][DEPTH-1:0]              ent_vld;
  logic  [NREQ-1:0][DEPTH-1:0][ADDR_W-1:0]  ent_addr;

  logic              gnt_vld, gnt_idx;
  wb_req             gnt;
  logic              rr_last_q, rr_last_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic [DATA_W-1:0] c_q, c_d;

  assign vld_in     = {req1_valid, req0_valid};
  assign din[0]     = {req0_addr, req0_data};
  assign din[1]     = {req1_addr, req1_data};
  // Ready is a pure function of queue state; a full queue popping this cycle still refuses.
  assign push       = vld_in & ~full;
  assign req0_ready = ~full[0];
  assign req1_ready = ~full[1];

  for (genvar g = 0; g < NREQ; g++) begin : g_q
    rf_wq_fifo #(.DEPTH(DEPTH)) u_q (
      .clk        (clk),
      .rst_n      (nClear),
      .push_i     (push[g]),
      .pop_i      (pop[g]),
      .din_i      (din[g]),
      .dout_o     (head[g]),
      .empty_o    (empty[g]),
      .full_o     (full[g]),
      .ent_vld_o  (ent_vld[g]),
      .ent_addr_o (ent_addr[g])
    );
  end

  // Heads come from registered state, so a same-cycle push is never eligible.
  always_comb begin
    gnt_vld   = ~&empty;
    gnt_idx   = (&(~empty)) ? ~rr_last_q : ~empty[1];
    pop       = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    gnt       = head[gnt_idx];
    rr_last_d = gnt_vld ? gnt_idx : rr_last_q;
    load_d    = gnt_vld && (gnt.addr != ADDR_W'(RF_ZERO_REG));
    caddr_d   = load_d ? gnt.addr : caddr_q;
    c_d       = load_d ? gnt.data : c_q;
  end

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      rr_last_q <= 1'b1;
      load_q    <= 1'b0;
      caddr_q   <= '0;
      c_q       <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      load_q    <= load_d;
      caddr_q   <= caddr_d;
      c_q       <= c_d;
    end
  end

  assign load  = load_q;
  assign Caddr = caddr_q;
  assign C     = c_q;
  assign busy  = ~&empty | load_q;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < DEPTH; j++)
        if (ent_vld[i][j]) pending[ent_addr[i][j]] = 1'b1;
    if (load_q) pending[caddr_q] = 1'b1;
    pending[RF_ZERO_REG] = 1'b0;
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a queue-level model, plus directed literal checks.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        nClear = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, load, busy;
  logic [3:0]  Caddr;
  logic [15:0] C;
  logic [15:0] pending;

  rf_write_arbiter dut (
    .clk(clk), .nClear(nClear),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .load(load), .Caddr(Caddr), .C(C), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] a; logic [15:0] d; } ent_t;

  ent_t        mq0[$], mq1[$];
  int          m_last;
  logic        m_load;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  logic [15:0] m_rf [16];
  logic [15:0] dut_rf [16];
  int          nerr = 0, nchk = 0;
  bit          cmp_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0;
    nClear = 0;
    step(); step();
    nClear = 1;
    step();
  endtask

  // Register file as the DUT actually writes it.
  always @(posedge clk) if (nClear && load) dut_rf[Caddr] <= C;

  // Model: at each negedge compare against the post-edge state, then advance to the next edge.
  initial begin
    for (int r = 0; r < 16; r++) begin m_rf[r] = '0; dut_rf[r] = '0; end
    forever begin
      @(negedge clk);
      if (!nClear) begin
        mq0.delete(); mq1.delete();
        m_last = 1; m_load = 0; m_addr = '0; m_data = '0;
      end
      if (cmp_on) begin
        logic [15:0] ep;
        ep = '0;
        foreach (mq0[i]) if (mq0[i].a != 0) ep[mq0[i].a] = 1'b1;
        foreach (mq1[i]) if (mq1[i].a != 0) ep[mq1[i].a] = 1'b1;
        if (m_load) ep[m_addr] = 1'b1;
        chk("ready0", req0_ready, mq0.size() < 2);
        chk("ready1", req1_ready, mq1.size() < 2);
        chk("load", load, m_load);
        if (m_load) begin
          chk("Caddr", Caddr, m_addr);
          chk("C", C, m_data);
        end
        chk("pending", pending, ep);
        chk("busy", busy, (mq0.size() > 0) || (mq1.size() > 0) || m_load);
      end
      if (nClear) begin
        bit   a0, a1;
        int   g;
        ent_t e;
        a0 = req0_valid && (mq0.size() < 2);
        a1 = req1_valid && (mq1.size() < 2);
        g = -1;
        if (mq0.size() > 0 && mq1.size() > 0) g = (m_last == 0) ? 1 : 0;
        else if (mq0.size() > 0) g = 0;
        else if (mq1.size() > 0) g = 1;
        m_load = 0;
        e = '0;
        if (g == 0) e = mq0.pop_front();
        else if (g == 1) e = mq1.pop_front();
        if (g >= 0) begin
          m_last = g;
          if (e.a != 0) begin
            m_load = 1; m_addr = e.a; m_data = e.d; m_rf[e.a] = e.d;
          end
        end
        if (a0) mq0.push_back({req0_addr, req0_data});
        if (a1) mq1.push_back({req1_addr, req1_data});
      end
    end
  end

  initial begin
    step(); step();
    nClear = 1;
    cmp_on = 1;
    step();
    // reset state
    chk("rst_load", load, 0);
    chk("rst_Caddr", Caddr, 0);
    chk("rst_C", C, 0);
    chk("rst_pending", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 1);
    chk("rst_ready1", req1_ready, 1);

    // single write: addr 5, data 1234
    req0_valid = 1; req0_addr = 4'd5; req0_data = 16'h1234;
    step();
    req0_valid = 0;
    chk("sw_k_load", load, 0);
    chk("sw_k_pend", pending, 16'h0020);
    chk("sw_k_busy", busy, 1);
    step();
    chk("sw_k1_load", load, 1);
    chk("sw_k1_Caddr", Caddr, 5);
    chk("sw_k1_C", C, 16'h1234);
    chk("sw_k1_pend", pending, 16'h0020);
    step();
    chk("sw_k2_load", load, 0);
    chk("sw_k2_pend", pending, 0);
    chk("sw_k2_busy", busy, 0);
    chk("sw_k2_Chold", C, 16'h1234);
    chk("sw_rf5", dut_rf[5], 16'h1234);

    // contention: alternating grants starting with req0, readies toggle
    do_reset();
    req0_valid = 1; req0_addr = 4'd3;
    req1_valid = 1; req1_addr = 4'd4;
    for (int n = 1; n <= 8; n++) begin
      req0_data = 16'h3000 + 16'(n);
      req1_data = 16'h4000 + 16'(n);
      step();
      if (n >= 2) begin
        chk("ct_load", load, 1);
        chk("ct_Caddr", Caddr, (n % 2 == 0) ? 3 : 4);
        chk("ct_ready0", req0_ready, (n % 2 == 0) ? 1 : 0);
        chk("ct_ready1", req1_ready, (n % 2 == 0) ? 0 : 1);
      end
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) step();

    // $zero write is consumed silently
    do_reset();
    req0_valid = 1; req0_addr = 4'd0; req0_data = 16'hFFFF;
    step();
    req0_valid = 0;
    chk("z_k_busy", busy, 1);
    chk("z_k_pend", pending, 0);
    step();
    chk("z_k1_load", load, 0);
    chk("z_k1_busy", busy, 0);
    step();
    chk("z_k2_load", load, 0);

    // same-register collision: req0 first, req1 last wins
    do_reset();
    req0_valid = 1; req0_addr = 4'd7; req0_data = 16'hAAAA;
    req1_valid = 1; req1_addr = 4'd7; req1_data = 16'h5555;
    step();
    req0_valid = 0; req1_valid = 0;
    chk("col_k_pend", pending, 16'h0080);
    step();
    chk("col_k1_load", load, 1);
    chk("col_k1_Caddr", Caddr, 7);
    chk("col_k1_C", C, 16'hAAAA);
    chk("col_k1_pend", pending, 16'h0080);
    step();
    chk("col_k2_load", load, 1);
    chk("col_k2_C", C, 16'h5555);
    chk("col_k2_pend", pending, 16'h0080);
    step();
    chk("col_k3_pend", pending, 0);
    chk("col_rf7", dut_rf[7], 16'h5555);

    // reset mid-stream with traffic queued
    do_reset();
    req0_valid = 1; req0_addr = 4'd9; req1_valid = 1; req1_addr = 4'd10;
    repeat (5) step();
    chk("mr_pre_load", load, 1);
    #2 nClear = 0;
    #1;
    chk("mr_load", load, 0);
    chk("mr_pend", pending, 0);
    chk("mr_busy", busy, 0);
    req0_valid = 0; req1_valid = 0;
    step(); step();
    nClear = 1;
    step();
    chk("mr_ready0", req0_ready, 1);
    chk("mr_ready1", req1_ready, 1);
    for (int n = 0; n < 4; n++) chk("mr_noload", load, 0);
    repeat (4) begin step(); chk("mr_idle_load", load, 0); end

    // randomized traffic, with an occasional asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_addr  = 4'($urandom_range(0, 9));
      req1_addr  = 4'($urandom_range(0, 9));
      req0_data  = 16'($urandom);
      req1_data  = 16'($urandom);
      step();
      if ($urandom_range(0, 499) == 0) begin
        #2 nClear = 0;
        step(); step();
        nClear = 1;
      end
    end
    req0_valid = 0; req1_valid = 0;
    repeat (6) step();
    chk("drain_busy", busy, 0);
    for (int r = 0; r < 16; r++) chk("final_rf", dut_rf[r], m_rf[r]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
